// File: rtl/strobe_capture_fifo_pkg.sv
// rtl/strobe_capture_fifo_pkg.sv - shared types and constants for the strobe capture FIFO
package strobe_capture_fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_PUSH   = 2'd2
   } capture_state_t;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 16;

   // One extra bit so a completely full FIFO is representable.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/strobe_capture_fifo_sync_fifo_reg.sv
// rtl/strobe_capture_fifo_sync_fifo_reg.sv - single-clock circular FIFO with registered read port
module sync_fifo_reg
   import strobe_capture_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_push,
   input  logic [DATA_WIDTH-1:0]         i_push_data,
   input  logic                          i_pop,
   output logic                          o_push_ready,
   output logic [DATA_WIDTH-1:0]         o_dout,
   output logic                          o_dout_valid,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [count_width(DEPTH)-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_dout_valid;

   logic w_pop_ok;
   logic w_push_ok;

   assign w_pop_ok     = i_pop && (r_count != '0);
   // A pop in the same cycle frees a slot, so a push at full still fits.
   assign o_push_ready = (r_count != CW'(DEPTH)) || w_pop_ok;
   assign w_push_ok    = i_push && o_push_ready;

   always_ff @(posedge i_clock) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_dout_valid <= w_pop_ok;
         if (w_pop_ok) begin
            r_dout   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_valid;
   assign o_count      = r_count;
   assign o_empty      = (r_count == '0);
   assign o_full       = (r_count == CW'(DEPTH));

endmodule

// File: rtl/strobe_capture_fifo.sv
// rtl/strobe_capture_fifo.sv - settle-delayed capture of MCU write data into a FIFO with sticky error flags
module strobe_capture_fifo
   import strobe_capture_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_strobe_pulse,
   input  logic [DATA_WIDTH-1:0]         i_data_in,
   input  logic                          i_rd_en,
   output logic [DATA_WIDTH-1:0]         o_dout,
   output logic                          o_dout_valid,
   output logic                          o_empty,
   output logic                          o_full,
   output logic [count_width(DEPTH)-1:0] o_count,
   output logic                          o_overflow,
   output logic                          o_missed,
   input  logic                          i_clear_flags
);

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   capture_state_t        r_state;
   logic [7:0]            r_settle_cnt;
   logic [DATA_WIDTH-1:0] r_d1;
   logic [DATA_WIDTH-1:0] r_d2;
   logic                  r_overflow;
   logic                  r_missed;

   logic w_push_req;
   logic w_push_ready;
   logic w_missed_set;
   logic w_overflow_set;

   // The bus is asynchronous; two flops bring it into the clock domain.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_d1 <= '0;
         r_d2 <= '0;
      end else begin
         r_d1 <= i_data_in;
         r_d2 <= r_d1;
      end
   end

   assign w_push_req     = (r_state == ST_PUSH);
   assign w_missed_set   = i_strobe_pulse && (r_state != ST_IDLE);
   assign w_overflow_set = w_push_req && !w_push_ready;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= '0;
         r_overflow   <= 1'b0;
         r_missed     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_strobe_pulse) begin
                  r_state      <= ST_SETTLE;
                  r_settle_cnt <= SETTLE_LOAD;
               end
            end
            ST_SETTLE: begin
               if (r_settle_cnt == '0) begin
                  r_state <= ST_PUSH;
               end else begin
                  r_settle_cnt <= r_settle_cnt - 8'd1;
               end
            end
            ST_PUSH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         // Set beats clear when both land in the same cycle.
         if (w_missed_set) begin
            r_missed <= 1'b1;
         end else if (i_clear_flags) begin
            r_missed <= 1'b0;
         end
         if (w_overflow_set) begin
            r_overflow <= 1'b1;
         end else if (i_clear_flags) begin
            r_overflow <= 1'b0;
         end
      end
   end

   sync_fifo_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_push       (w_push_req),
      .i_push_data  (r_d2),
      .i_pop        (i_rd_en),
      .o_push_ready (w_push_ready),
      .o_dout       (o_dout),
      .o_dout_valid (o_dout_valid),
      .o_full       (o_full),
      .o_empty      (o_empty),
      .o_count      (o_count)
   );

   assign o_overflow = r_overflow;
   assign o_missed   = r_missed;

endmodule
